aes_axis_out_buffer: RTL



---
 rtl/aes_axis_out_buffer_pkg.sv | 21 ++
 rtl/aes_axis_fifo_mem.sv | 34 +++
 rtl/aes_axis_out_buffer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_axis_out_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_axis_out_buffer_pkg
// Brief    : Shared constants, types and helpers for the AES AXIS output buffer
// Revision : 1.0
// ============================================================================
package aes_axis_out_buffer_pkg;

    localparam int c_WORD_S    = 32;   // stream word width
    localparam int c_NB        = 4;    // words per AES block
    localparam int c_BLK_CNT_W = 16;   // per-packet block counter width

    typedef logic [c_BLK_CNT_W-1:0] blk_cnt_t;

    // RAM depth is 2**N-1, so pointers need an explicit modulo wrap
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned modulus);
        return (ptr + 32'd1 >= modulus) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_axis_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : aes_axis_fifo_mem
// Brief    : Simple dual-port RAM, one synchronous write and one synchronous
//            read port; a same-address write is forwarded to the read data.
// Revision : 1.0
// ============================================================================
module aes_axis_fifo_mem #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 31,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata_q <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
    end

    assign o_rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/aes_axis_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : aes_axis_out_buffer
// Brief    : FWFT buffer between the AES stream engine and DMA S2MM with
//            per-packet block counting. AES_OUT_STORE_FWD_EN enables
//            store-and-forward with cut-through fallback when full.
// Revision : 1.0
// ============================================================================
module aes_axis_out_buffer
    import aes_axis_out_buffer_pkg::*;
#(
    parameter int DATA_WIDTH    = c_WORD_S,
    parameter int ADDR_WIDTH    = 5,
    parameter int WORDS_PER_BLK = c_NB
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [ADDR_WIDTH:0]    level,
    output logic [c_BLK_CNT_W-1:0] pkt_blk_cnt,
    output logic                   pkt_done,
    output logic                   err_unaligned
);

    localparam int unsigned         c_DEPTH_I   = 2**ADDR_WIDTH;
    localparam int unsigned         c_RAM_DEPTH = c_DEPTH_I - 1;
    localparam logic [ADDR_WIDTH:0] c_DEPTH     = (ADDR_WIDTH+1)'(c_DEPTH_I);
    localparam int                  c_WI_W      = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;
    localparam logic [c_WI_W-1:0]   c_WI_LAST   = c_WI_W'(WORDS_PER_BLK - 1);
    localparam blk_cnt_t            c_BLK_MAX   = '1;

    logic [ADDR_WIDTH:0]   r_level_q, w_level_d, w_ram_cnt;
    logic                  r_vld_q, w_vld_d;
    logic [DATA_WIDTH-1:0] r_data_q, w_data_d;
    logic                  r_last_q, w_last_d;
    logic [ADDR_WIDTH-1:0] r_wr_ptr_q, w_wr_ptr_d, r_rd_ptr_q, w_rd_ptr_d, w_raddr;
    logic [c_WI_W-1:0]     r_wi_q, w_wi_d;
    blk_cnt_t              r_bc_q, w_bc_d, r_blk_cnt_q, w_blk_cnt_d;
    logic                  r_done_q, w_done_d, r_err_q, w_err_d;
    logic                  w_push, w_pop, w_out_vld, w_load, w_from_ram, w_ram_we, w_blk_end;
    logic [DATA_WIDTH:0]   w_rd_word;

    // Ready depends only on the registered level; reset holds it low
    assign s_axis_tready = (r_level_q != c_DEPTH) && !reset;
    assign w_push        = s_axis_tvalid && s_axis_tready;
    assign w_pop         = w_out_vld && m_axis_tready;
    assign w_ram_cnt     = r_level_q - (ADDR_WIDTH+1)'(r_vld_q);
    assign w_load        = !r_vld_q || w_pop;
    assign w_from_ram    = w_load && (w_ram_cnt != '0);
    assign w_ram_we      = w_push && !(w_load && (w_ram_cnt == '0));
    assign w_raddr       = reset ? '0 : w_rd_ptr_d;
    assign w_blk_end     = (r_wi_q == c_WI_LAST);

    aes_axis_fifo_mem #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (c_RAM_DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr_q),
        .i_wdata ({s_axis_tlast, s_axis_tdata}),
        .i_raddr (w_raddr),
        .o_rdata (w_rd_word)
    );

    always_comb begin
        w_level_d  = r_level_q;
        w_vld_d    = r_vld_q;
        w_data_d   = r_data_q;
        w_last_d   = r_last_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_wr_ptr_d = r_wr_ptr_q;
        if (w_push && !w_pop) begin
            w_level_d = r_level_q + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_d = r_level_q - 1'b1;
        end
        // Output register refills from RAM first, else straight from the input
        if (w_load) begin
            if (w_from_ram) begin
                w_vld_d               = 1'b1;
                {w_last_d, w_data_d}  = w_rd_word;
                w_rd_ptr_d            = ADDR_WIDTH'(wrap_inc(32'(r_rd_ptr_q), c_RAM_DEPTH));
            end else if (w_push) begin
                w_vld_d  = 1'b1;
                w_data_d = s_axis_tdata;
                w_last_d = s_axis_tlast;
            end else begin
                w_vld_d  = 1'b0;
            end
        end
        if (w_ram_we) begin
            w_wr_ptr_d = ADDR_WIDTH'(wrap_inc(32'(r_wr_ptr_q), c_RAM_DEPTH));
        end
    end

    always_comb begin
        w_wi_d      = r_wi_q;
        w_bc_d      = r_bc_q;
        w_blk_cnt_d = r_blk_cnt_q;
        w_err_d     = r_err_q;
        w_done_d    = w_pop && r_last_q;
        if (w_push) begin
            if (s_axis_tlast) begin
                w_blk_cnt_d = (w_blk_end && (r_bc_q != c_BLK_MAX)) ? r_bc_q + 1'b1 : r_bc_q;
                w_wi_d      = '0;
                w_bc_d      = '0;
                if (!w_blk_end) begin
                    w_err_d = 1'b1;
                end
            end else begin
                w_wi_d = w_blk_end ? '0 : r_wi_q + 1'b1;
                if (w_blk_end && (r_bc_q != c_BLK_MAX)) begin
                    w_bc_d = r_bc_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level_q   <= '0;
            r_vld_q     <= 1'b0;
            r_data_q    <= '0;
            r_last_q    <= 1'b0;
            r_wr_ptr_q  <= '0;
            r_rd_ptr_q  <= '0;
            r_wi_q      <= '0;
            r_bc_q      <= '0;
            r_blk_cnt_q <= '0;
            r_done_q    <= 1'b0;
            r_err_q     <= 1'b0;
        end else begin
            r_level_q   <= w_level_d;
            r_vld_q     <= w_vld_d;
            r_data_q    <= w_data_d;
            r_last_q    <= w_last_d;
            r_wr_ptr_q  <= w_wr_ptr_d;
            r_rd_ptr_q  <= w_rd_ptr_d;
            r_wi_q      <= w_wi_d;
            r_bc_q      <= w_bc_d;
            r_blk_cnt_q <= w_blk_cnt_d;
            r_done_q    <= w_done_d;
            r_err_q     <= w_err_d;
        end
    end

`ifdef AES_OUT_STORE_FWD_EN
    logic [ADDR_WIDTH:0] r_pkt_avail_q, w_pkt_avail_d;
    logic                r_cut_q, w_cut_d, w_full_no_pkt, w_last_in, w_last_out;

    // A full buffer without any complete packet must stream or it deadlocks
    assign w_full_no_pkt = (r_level_q == c_DEPTH) && (r_pkt_avail_q == '0);
    assign w_out_vld     = r_vld_q && ((r_pkt_avail_q != '0) || r_cut_q || w_full_no_pkt);
    assign w_last_in     = w_push && s_axis_tlast;
    assign w_last_out    = w_pop && r_last_q;

    always_comb begin
        w_pkt_avail_d = r_pkt_avail_q;
        w_cut_d       = r_cut_q;
        if (w_last_in && !w_last_out) begin
            w_pkt_avail_d = r_pkt_avail_q + 1'b1;
        end else if (!w_last_in && w_last_out) begin
            w_pkt_avail_d = r_pkt_avail_q - 1'b1;
        end
        if (w_last_out) begin
            w_cut_d = 1'b0;
        end else if (w_full_no_pkt) begin
            w_cut_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_avail_q <= '0;
            r_cut_q       <= 1'b0;
        end else begin
            r_pkt_avail_q <= w_pkt_avail_d;
            r_cut_q       <= w_cut_d;
        end
    end
`else
    assign w_out_vld = r_vld_q;
`endif

    assign m_axis_tdata  = r_data_q;
    assign m_axis_tvalid = w_out_vld;
    assign m_axis_tlast  = r_last_q;
    assign level         = r_level_q;
    assign pkt_blk_cnt   = r_blk_cnt_q;
    assign pkt_done      = r_done_q;
    assign err_unaligned = r_err_q;

endmodule
`default_nettype wire
